// File: rtl/pkg_tamagotchi.sv
// Shared types and default timing for the pet controller front-end.
// The action codes double as the accion_id output encoding.
package pkg_tamagotchi;

    localparam int CLK_HZ       = 50_000_000;
    localparam int DEBOUNCE_CYC = 1_000_000;    // 20 ms at CLK_HZ
    localparam int LONG_CYC     = 250_000_000;  // 5 s at CLK_HZ
    localparam int COOLDOWN_CYC = 25_000_000;   // 0.5 s at CLK_HZ
    localparam int CNT_W        = 28;

    typedef enum logic [2:0] {
        ACC_NINGUNA    = 3'd0,
        ACC_COMER      = 3'd1,
        ACC_JUGAR      = 3'd2,
        ACC_DORMIR     = 3'd3,
        ACC_TEST_CORTO = 3'd4,
        ACC_TEST_LARGO = 3'd5,
        ACC_REINICIO   = 3'd6
    } accion_e;

    typedef enum logic [2:0] {
        LIBRE,
        MANTENER_TEST,
        MANTENER_REINICIO,
        ESPERA_SOLTAR,
        ENFRIAR
    } estado_e;

    // Pulse vector bit (code - 1) is the pulse for that action.
    function automatic logic [5:0] pulso_de(accion_e a);
        logic [5:0] p;
        p = '0;
        if (a != ACC_NINGUNA) begin
            p = 6'b000001 << (3'(a) - 3'd1);
        end
        return p;
    endfunction

endpackage

// File: rtl/arbitro_botones_if.sv
// Button/pulse bundle between the user-input front-end and its neighbours.
interface arbitro_botones_if;

    logic       btn_comer;
    logic       btn_jugar;
    logic       btn_dormir;
    logic       btn_test;
    logic       btn_reinicio;
    logic       bloqueo;
    logic       pulso_comer;
    logic       pulso_jugar;
    logic       pulso_dormir;
    logic       pulso_test_corto;
    logic       pulso_test_largo;
    logic       pulso_reinicio;
    logic       ocupado;
    logic [2:0] accion_id;

    modport master (
        output btn_comer, btn_jugar, btn_dormir, btn_test, btn_reinicio, bloqueo,
        input  pulso_comer, pulso_jugar, pulso_dormir, pulso_test_corto,
               pulso_test_largo, pulso_reinicio, ocupado, accion_id
    );

    modport slave (
        input  btn_comer, btn_jugar, btn_dormir, btn_test, btn_reinicio, bloqueo,
        output pulso_comer, pulso_jugar, pulso_dormir, pulso_test_corto,
               pulso_test_largo, pulso_reinicio, ocupado, accion_id
    );

endinterface

// File: rtl/antirrebote.sv
// One button: 2-FF synchroniser, stability counter, debounced level and a
// registered rise strobe.
module antirrebote #(
    parameter int DEBOUNCE_CYC = 4,
    parameter int CNT_W        = 28
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic level_o,
    output logic rise_o
);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             armed_q, armed_d;
    logic [1:0]       vld_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // A button found held when the synchroniser first fills must be seen
    // released before it can produce a rise, so a press across reset is ignored.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        armed_d = armed_q | (vld_q[1] & ~sync2_q & ~level_q);
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q >= CNT_W'(DEBOUNCE_CYC - 1)) begin
            level_d = sync2_q;
            cnt_d   = '0;
            rise_d  = sync2_q & armed_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            vld_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            armed_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            vld_q   <= {vld_q[0], 1'b1};
            level_q <= level_d;
            rise_q  <= rise_d;
            armed_q <= armed_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;

endmodule

// File: rtl/arbitro_botones.sv
// User-input scheduler: conditions five buttons, arbitrates presses and
// emits at most one clean single-cycle action pulse per cooldown window.
module arbitro_botones #(
    parameter int DEBOUNCE_CYC = pkg_tamagotchi::DEBOUNCE_CYC,
    parameter int LONG_CYC     = pkg_tamagotchi::LONG_CYC,
    parameter int COOLDOWN_CYC = pkg_tamagotchi::COOLDOWN_CYC,
    parameter int CNT_W        = pkg_tamagotchi::CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    arbitro_botones_if.slave  bus
);

    import pkg_tamagotchi::*;

    // Bit order: 0 comer, 1 jugar, 2 dormir, 3 test, 4 reinicio.
    logic [4:0] btn, lvl, rise;

    assign btn = {bus.btn_reinicio, bus.btn_test, bus.btn_dormir,
                  bus.btn_jugar, bus.btn_comer};

    for (genvar g = 0; g < 5; g++) begin : g_ar
        antirrebote #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC),
            .CNT_W        (CNT_W)
        ) u_ar (
            .clk_i   (clk),
            .rst_ni  (reset),
            .btn_i   (btn[g]),
            .level_o (lvl[g]),
            .rise_o  (rise[g])
        );
    end

    estado_e          st_q, st_d;
    accion_e          acc_q, acc_d, gana;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [5:0]       pul_q, pul_d;

    always_comb begin
        st_d  = st_q;
        cnt_d = cnt_q;
        acc_d = acc_q;
        pul_d = '0;
        gana  = ACC_NINGUNA;
        case (st_q)
            LIBRE: begin
                if (!bus.bloqueo) begin
                    if (rise[0])      gana = ACC_COMER;
                    else if (rise[1]) gana = ACC_JUGAR;
                    else if (rise[2]) gana = ACC_DORMIR;
                end
                if (rise[4]) begin
                    cnt_d = '0;
                    st_d  = MANTENER_REINICIO;
                end else if (rise[3]) begin
                    cnt_d = '0;
                    st_d  = MANTENER_TEST;
                end else if (gana != ACC_NINGUNA) begin
                    acc_d = gana;
                    pul_d = pulso_de(gana);
                    st_d  = ESPERA_SOLTAR;
                end
            end
            MANTENER_TEST: begin
                if (lvl[3]) begin
                    if (cnt_q >= CNT_W'(LONG_CYC - 1)) begin
                        acc_d = ACC_TEST_LARGO;
                        pul_d = pulso_de(ACC_TEST_LARGO);
                        st_d  = ESPERA_SOLTAR;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    acc_d = ACC_TEST_CORTO;
                    pul_d = pulso_de(ACC_TEST_CORTO);
                    cnt_d = '0;
                    st_d  = ENFRIAR;
                end
            end
            MANTENER_REINICIO: begin
                if (lvl[4]) begin
                    if (cnt_q >= CNT_W'(LONG_CYC - 1)) begin
                        acc_d = ACC_REINICIO;
                        pul_d = pulso_de(ACC_REINICIO);
                        st_d  = ESPERA_SOLTAR;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    st_d = LIBRE;
                end
            end
            ESPERA_SOLTAR: begin
                if (lvl == '0) begin
                    cnt_d = '0;
                    st_d  = ENFRIAR;
                end
            end
            ENFRIAR: begin
                if (cnt_q >= CNT_W'(COOLDOWN_CYC - 1)) begin
                    st_d = LIBRE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: st_d = LIBRE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_q  <= LIBRE;
            acc_q <= ACC_NINGUNA;
            cnt_q <= '0;
            pul_q <= '0;
        end else begin
            st_q  <= st_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            pul_q <= pul_d;
        end
    end

    assign bus.pulso_comer      = pul_q[0];
    assign bus.pulso_jugar      = pul_q[1];
    assign bus.pulso_dormir     = pul_q[2];
    assign bus.pulso_test_corto = pul_q[3];
    assign bus.pulso_test_largo = pul_q[4];
    assign bus.pulso_reinicio   = pul_q[5];
    assign bus.ocupado          = (st_q != LIBRE);
    assign bus.accion_id        = acc_q;

endmodule

// File: tb/tb_arbitro_botones.sv
// Directed bench for arbitro_botones with a scoreboard of expected pulses
// (vector, accion_id and, where fixed, the exact cycle of appearance).
module tb_arbitro_botones;

    import pkg_tamagotchi::*;

    logic clk = 1'b0;
    logic reset;
    arbitro_botones_if bus();

    always #5 clk = ~clk;

    arbitro_botones #(
        .DEBOUNCE_CYC (4),
        .LONG_CYC     (40),
        .COOLDOWN_CYC (10),
        .CNT_W        (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [5:0] pul;
        accion_e    id;
        int         at;
    } esperado_t;

    esperado_t  sb[$];
    esperado_t  mon_e;
    int         tests = 0;
    int         fails = 0;
    int         cyc   = 0;
    int         t1;
    logic [5:0] pul;

    assign pul = {bus.pulso_reinicio, bus.pulso_test_largo, bus.pulso_test_corto,
                  bus.pulso_dormir, bus.pulso_jugar, bus.pulso_comer};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset === 1'b1 && pul !== 6'b0) begin
            check("un_solo_pulso", 32'($onehot(pul)), 32'd1);
            if (sb.size() == 0) begin
                check("pulso_inesperado", 32'(pul), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("pulso", 32'(pul), 32'(mon_e.pul));
                check("accion_id", 32'(bus.accion_id), 32'(mon_e.id));
                if (mon_e.at >= 0) check("latencia", cyc, mon_e.at);
            end
        end
    end

    task automatic ciclos(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic esperar_vacio(string tag, int lim);
        int k = 0;
        while (sb.size() != 0 && k < lim) begin
            ciclos(1);
            k++;
        end
        check(tag, 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task automatic esperar_libre(string tag, int lim);
        int k = 0;
        while (bus.ocupado !== 1'b0 && k < lim) begin
            ciclos(1);
            k++;
        end
        check(tag, 32'(bus.ocupado), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset            = 1'b0;
        bus.btn_comer    = 1'b0;
        bus.btn_jugar    = 1'b0;
        bus.btn_dormir   = 1'b0;
        bus.btn_test     = 1'b0;
        bus.btn_reinicio = 1'b0;
        bus.bloqueo      = 1'b0;
        ciclos(3);
        check("reset_pulsos", 32'(pul), 32'd0);
        check("reset_ocupado", 32'(bus.ocupado), 32'd0);
        check("reset_accion", 32'(bus.accion_id), 32'd0);
        reset = 1'b1;
        ciclos(5);

        // 1: bouncing comer, then stable; pulse 7 cycles after the last rise
        for (int i = 0; i < 5; i++) begin
            bus.btn_comer = 1'b1;
            if (i == 4) sb.push_back('{6'b000001, ACC_COMER, cyc + 7});
            ciclos(2);
            if (i < 4) begin
                bus.btn_comer = 1'b0;
                ciclos(2);
            end
        end
        ciclos(6);
        check("c1_ocupado", 32'(bus.ocupado), 32'd1);
        check("c1_accion", 32'(bus.accion_id), 32'(ACC_COMER));
        esperar_vacio("c1_vacio", 10);
        bus.btn_comer = 1'b0;
        esperar_libre("c1_libre", 60);

        // 2: simultaneous jugar+dormir, dormir during cooldown, dormir after
        ciclos(2);
        bus.btn_jugar  = 1'b1;
        bus.btn_dormir = 1'b1;
        sb.push_back('{6'b000010, ACC_JUGAR, cyc + 7});
        ciclos(10);
        bus.btn_jugar  = 1'b0;
        bus.btn_dormir = 1'b0;
        t1 = cyc;
        esperar_vacio("c2_vacio_jugar", 5);
        ciclos(t1 + 8 - cyc);
        check("c2_enfriar_ocupado", 32'(bus.ocupado), 32'd1);
        bus.btn_dormir = 1'b1;
        ciclos(5);
        bus.btn_dormir = 1'b0;
        esperar_libre("c2_libre_enfriar", 40);
        ciclos(10);
        bus.btn_dormir = 1'b1;
        sb.push_back('{6'b000100, ACC_DORMIR, cyc + 7});
        ciclos(10);
        bus.btn_dormir = 1'b0;
        esperar_vacio("c2_vacio_dormir", 5);
        esperar_libre("c2_libre", 40);

        // 3: short test press, pulse follows debounced release
        ciclos(2);
        bus.btn_test = 1'b1;
        ciclos(20);
        bus.btn_test = 1'b0;
        sb.push_back('{6'b001000, ACC_TEST_CORTO, cyc + 7});
        esperar_vacio("c3_vacio", 30);
        esperar_libre("c3_libre", 40);

        // 4: long test press, single largo pulse, nothing on release
        ciclos(2);
        bus.btn_test = 1'b1;
        sb.push_back('{6'b010000, ACC_TEST_LARGO, cyc + 47});
        ciclos(60);
        bus.btn_test = 1'b0;
        esperar_vacio("c4_vacio", 5);
        esperar_libre("c4_libre", 40);
        ciclos(5);

        // 5: bloqueo masks comer but not reinicio; bloqueo change mid-hold
        ciclos(2);
        bus.bloqueo   = 1'b1;
        bus.btn_comer = 1'b1;
        ciclos(10);
        check("c5_bloqueo_libre", 32'(bus.ocupado), 32'd0);
        check("c5_bloqueo_accion", 32'(bus.accion_id), 32'(ACC_TEST_LARGO));
        bus.btn_comer = 1'b0;
        ciclos(10);
        bus.btn_reinicio = 1'b1;
        sb.push_back('{6'b100000, ACC_REINICIO, cyc + 47});
        ciclos(20);
        bus.bloqueo = 1'b0;
        ciclos(30);
        bus.btn_reinicio = 1'b0;
        esperar_vacio("c5_vacio", 5);
        esperar_libre("c5_libre", 40);

        // 6: reset at hold count 30, test kept held afterwards
        ciclos(2);
        bus.btn_test = 1'b1;
        ciclos(37);
        reset = 1'b0;
        #1;
        check("c6_reset_pulsos", 32'(pul), 32'd0);
        check("c6_reset_ocupado", 32'(bus.ocupado), 32'd0);
        check("c6_reset_accion", 32'(bus.accion_id), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        ciclos(80);
        check("c6_sin_accion", 32'(bus.ocupado), 32'd0);
        bus.btn_test = 1'b0;
        ciclos(15);
        bus.btn_comer = 1'b1;
        sb.push_back('{6'b000001, ACC_COMER, cyc + 7});
        ciclos(10);
        bus.btn_comer = 1'b0;
        esperar_vacio("c6_vacio", 5);
        esperar_libre("c6_libre", 40);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
